// File: rtl/bin_video_pattern_gen_pkg.sv
// Shared types and constants for the binary video pattern generator.
package bin_video_pkg;

  typedef enum logic [1:0] {
    PAT_CHECK  = 2'd0,
    PAT_BORDER = 2'd1,
    PAT_DOT    = 2'd2,
    PAT_NOISE  = 2'd3
  } pat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

endpackage

// File: rtl/bin_video_pattern_gen_lfsr16_gen.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr16_gen
  import bin_video_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (seed_load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bin_video_pattern_gen.sv
// 1-bit video frame source: raster counters, run/idle FSM and test-pattern decode.
module bin_video_pattern_gen
  import bin_video_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int H_BLANK    = 280,
  parameter int V_BLANK    = 45,
  parameter int VS_LINES   = 5,
  parameter int CELL_LOG2  = 3
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic       gen_en,
  input  logic [1:0] pattern_sel,
  output logic       video_vs,
  output logic       video_de,
  output logic       video_data,
  output logic       frame_done
);

  localparam logic [11:0] H_MAX  = 12'(IMG_WIDTH + H_BLANK - 1);
  localparam logic [11:0] V_MAX  = 12'(V_BLANK + IMG_HEIGHT - 1);
  localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);
  localparam logic [11:0] VB     = 12'(V_BLANK);
  localparam logic [11:0] VSL    = 12'(VS_LINES);
  localparam logic [11:0] W      = 12'(IMG_WIDTH);

  state_t      state, state_next;
  logic [11:0] h_cnt, v_cnt, h_next, v_next;
  pat_t        pat_q;
  logic [15:0] lfsr_q;
  logic [14:0] lfsr_unused;
  logic        run, line_end, frame_end, frame_start;
  logic        vs_d, de_d, data_d, pix;
  logic [11:0] x, y;

  assign run         = (state == ST_RUN);
  assign line_end    = (h_cnt == H_MAX);
  assign frame_end   = line_end && (v_cnt == V_MAX);
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign x           = h_cnt;
  assign y           = v_cnt - VB;
  assign lfsr_unused = lfsr_q[15:1];

  always_comb begin
    state_next = state;
    h_next     = h_cnt;
    v_next     = v_cnt;
    case (state)
      ST_IDLE: begin
        h_next = '0;
        v_next = '0;
        if (gen_en) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (frame_end) begin
          h_next = '0;
          v_next = '0;
          if (!gen_en) state_next = ST_IDLE;
        end else if (line_end) begin
          h_next = '0;
          v_next = v_cnt + 12'd1;
        end else begin
          h_next = h_cnt + 12'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        h_next     = '0;
        v_next     = '0;
      end
    endcase
  end

  always_comb begin
    vs_d = run && (v_cnt < VSL);
    de_d = run && (v_cnt >= VB) && (h_cnt < W);
    pix  = 1'b0;
    case (pat_q)
      PAT_CHECK:  pix = x[CELL_LOG2] ^ y[CELL_LOG2];
      PAT_BORDER: pix = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
      PAT_DOT:    pix = (x[CELL_LOG2-1:0] == '0) && (y[CELL_LOG2-1:0] == '0);
      PAT_NOISE:  pix = lfsr_q[0];
      default:    pix = 1'b0;
    endcase
    data_d = de_d && pix;
  end

  // LFSR steps only on active pixels so every frame replays the same noise.
  lfsr16_gen u_lfsr (
    .clk       (video_clk),
    .rst_n     (rst_n),
    .seed_load (frame_start),
    .step      (de_d),
    .q         (lfsr_q)
  );

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      pat_q <= PAT_CHECK;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
      if (frame_start) pat_q <= pat_t'(pattern_sel);
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      video_vs   <= 1'b0;
      video_de   <= 1'b0;
      video_data <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      video_vs   <= vs_d;
      video_de   <= de_d;
      video_data <= data_d;
      frame_done <= run && frame_end;
    end
  end

endmodule

// File: doc/bin_video_pattern_gen.md
# bin_video_pattern_gen

Frame source for the 1-bit binary video path. It generates `video_vs`, `video_de` and `video_data` with programmable blanking and one of four selectable test patterns. It drives the 3x3 window generator and the erosion/dilation chain directly in place of the binarisation stage, for simulation and on-board bring-up.

## Interface
- `IMG_WIDTH`, 1920: active pixels per line.
- `IMG_HEIGHT`, 1080: active lines per frame.
- `H_BLANK`, 280: blank cycles per line, following the active pixels.
- `V_BLANK`, 45: blank lines per frame, preceding the active lines.
- `VS_LINES`, 5: lines at the start of `V_BLANK` with `video_vs` high. Must satisfy 1 ≤ `VS_LINES` ≤ `V_BLANK`.
- `CELL_LOG2`, 3: log2 of the checkerboard cell size and of the dot-grid pitch.
- `video_clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gen_en`  in  1  level-sensitive run request.
- `pattern_sel`  in  2  pattern select: 0 checker, 1 border, 2 dot grid, 3 LFSR noise.
- `video_vs`  out  1  frame sync, active high.
- `video_de`  out  1  pixel valid.
- `video_data`  out  1  binary pixel; 0 whenever `video_de` = 0.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- **Counters**
  - `h_cnt` runs 0..`IMG_WIDTH`+`H_BLANK`-1.
  - `v_cnt` runs 0..`V_BLANK`+`IMG_HEIGHT`-1 and advances when `h_cnt` wraps.
  - Both counters are 12 bits; totals above 4095 are illegal.
- **FSM states:** IDLE and RUN.
  - IDLE: counters held at 0; all outputs 0. If `gen_en`=1, go to RUN on the next cycle.
  - RUN: counters advance every cycle.
  - At the frame-end cycle (both counters at maximum):
    - `frame_done`=1 for that cycle.
    - Counters wrap to 0.
    - If `gen_en`=0, go to IDLE; otherwise start the next frame immediately with no gap.
  - `gen_en` is only evaluated in IDLE and at frame end. Dropping it mid-frame lets the current frame complete.
- **Pattern select:** `pattern_sel` is latched into `pat_q` on the first cycle of every frame (RUN with `h_cnt`=0, `v_cnt`=0). Changes mid-frame have no effect.
- **Output decode**
  - `video_vs` = RUN and `v_cnt` < `VS_LINES`.
  - `video_de` = RUN and `v_cnt` ≥ `V_BLANK` and `h_cnt` < `IMG_WIDTH`.
  - Pattern coordinates: x = `h_cnt`, y = `v_cnt`-`V_BLANK`.
- **Patterns** (c = `CELL_LOG2`)
  - 0 checker: x[c] ^ y[c].
  - 1 border: 1 if x=0, x=`IMG_WIDTH`-1, y=0 or y=`IMG_HEIGHT`-1; else 0.
  - 2 dot grid: 1 if x[c-1:0]=0 and y[c-1:0]=0. These are isolated pixels: erosion removes all of them, dilation turns each into a 3x3 block.
  - 3 noise: bit 0 of a 16-bit LFSR.
    - Feedback: fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
    - Seeded with 16'hACE1 at reset and on every frame's first cycle.
    - Advances only on cycles where the decoded `video_de` is 1, so the sequence repeats identically every frame.

## Timing
- All four outputs are registered, with a fixed latency of 1 cycle after the counter state that produces them.
- `video_de` and `video_data` are registered together and are always cycle-aligned.
- `video_de` is high for exactly `IMG_WIDTH` consecutive cycles per active line. There are `IMG_HEIGHT` such bursts per frame.
- The `video_vs` falling edge precedes the first `video_de` of the frame by (`V_BLANK`-`VS_LINES`)·(`IMG_WIDTH`+`H_BLANK`) cycles.
- Frame period is (`IMG_WIDTH`+`H_BLANK`)·(`V_BLANK`+`IMG_HEIGHT`) cycles. Back-to-back frames have no extra idle cycle.
- Going from IDLE to the first `video_vs`=1 takes 2 cycles after `gen_en` is sampled high: 1 cycle for the state change, 1 for the output register.
- Reset values: every output 0, FSM in IDLE, counters 0, `pat_q`=0, LFSR=16'hACE1.
- Asserting `rst_n` low mid-frame forces all outputs to 0 immediately (asynchronously). No partial frame resumes after release.

## Structure
- Shared package `bin_video_pkg` holds:
  - pattern codes `PAT_CHECK`/`PAT_BORDER`/`PAT_DOT`/`PAT_NOISE`;
  - `LFSR_SEED` = 16'hACE1;
  - FSM state encodings `ST_IDLE`/`ST_RUN`.
- One natural sub-module: `lfsr16_gen`, with ports `clk`, `rst_n`, `seed_load`, `step`, `q[15:0]`.
- Counters, FSM and pattern decode stay in the top module.

## Test plan
Common bench parameters: `IMG_WIDTH`=8, `IMG_HEIGHT`=4, `H_BLANK`=4, `V_BLANK`=3, `VS_LINES`=1, `CELL_LOG2`=1.

- **Reset.** Hold `rst_n`=0 with `gen_en`=1 → all outputs 0. Release → first `video_vs`=1 appears 2 cycles later.
- **Single frame.** Pulse `gen_en` for 1 cycle → one frame of 84 cycles: `video_vs` high for 12 cycles, then 4 bursts of 8 `video_de`. `frame_done` pulses once, then the block returns to IDLE with outputs 0.
- **Checker.** `pattern_sel`=0 → lines 0 and 1 are 00110011; lines 2 and 3 are 11001100.
- **Border and dot.**
  - `pattern_sel`=1 → lines 0 and 3 are 11111111; lines 1 and 2 are 10000001.
  - `pattern_sel`=2 → lines 0 and 2 are 10101010; lines 1 and 3 are 00000000.
- **Noise repeatability.** `pattern_sel`=3 with `gen_en` held high for 2 frames → the 32 data bits of frame 2 match frame 1 and match the reference LFSR model seeded with 16'hACE1.
- **Mid-frame events.**
  - Change `pattern_sel` and drop `gen_en` during line 1 → the frame completes with the original pattern, `frame_done` pulses, then the block returns to IDLE.
  - Async reset during line 2 → outputs are 0 in the same cycle.
